// File: rtl/permutation_result_collector.sv
// Sums each bot's per-permutation results into one series total and queues totals in a show-ahead FIFO.
// Optional count checking is built when PERMUTATION_COLLECTOR_COUNT_CHECK_EN is defined.
module permutation_result_collector #(
  parameter int RESULT_WIDTH       = 48,
  parameter int SUM_WIDTH          = 54,
  parameter int SERIES_LENGTH      = 42,
  parameter int DEPTH_LOG2         = 4,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RESULT_WIDTH-1:0] resultIn,
  input  logic                    resultInValid,
  input  logic                    botSeriesFinished,
  output logic                    slowDown,
  output logic [SUM_WIDTH-1:0]    seriesSum,
  output logic                    seriesSumValid,
  input  logic                    readSeriesSum,
  output logic [15:0]             seriesCount,
  output logic                    overflowError,
  output logic                    countError
);

  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int THRESHOLD = DEPTH - ALMOST_FULL_MARGIN;

  logic [RESULT_WIDTH-1:0] s1_data;
  logic                    s1_valid;
  logic                    s1_finish;
  logic [SUM_WIDTH-1:0]    acc;
  logic [SUM_WIDTH-1:0]    sum_next;
  logic [15:0]             series_count;
  logic [15:0]             count_inc;
  logic                    s1_close;
  logic [SUM_WIDTH-1:0]    s2_data;
  logic                    s2_valid;

  assign sum_next  = acc + SUM_WIDTH'(s1_data);
  assign count_inc = (series_count == 16'hFFFF) ? series_count : series_count + 16'd1;
  assign s1_close  = s1_valid & s1_finish;

  // The closing element resets acc/count in the same cycle so a following series loses nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data      <= '0;
      s1_valid     <= 1'b0;
      s1_finish    <= 1'b0;
      acc          <= '0;
      series_count <= '0;
      s2_data      <= '0;
      s2_valid     <= 1'b0;
    end else begin
      s1_data   <= resultIn;
      s1_valid  <= resultInValid;
      s1_finish <= resultInValid & botSeriesFinished;
      s2_valid  <= s1_close;
      if (s1_close) begin
        s2_data      <= sum_next;
        acc          <= '0;
        series_count <= '0;
      end else if (s1_valid) begin
        acc          <= sum_next;
        series_count <= count_inc;
      end
    end
  end

  // Output handshake: seriesSum is valid whenever seriesSumValid=1; a cycle with
  // readSeriesSum=1 and seriesSumValid=1 pops the head, otherwise readSeriesSum is ignored.
  logic [SUM_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DEPTH_LOG2:0]   occupancy;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  pending;
  logic [DEPTH_LOG2+1:0] fill;
  logic                  near_full;

  assign occupancy = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign pop       = readSeriesSum & ~empty;
  assign push      = s2_valid & (~full | pop);
  assign pending   = (series_count != 16'd0) | s1_valid | s2_valid;
  assign fill      = {1'b0, occupancy} + {{(DEPTH_LOG2+1){1'b0}}, pending};
  assign near_full = (int'(fill) >= THRESHOLD);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= s2_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      overflowError <= 1'b0;
      slowDown      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (s2_valid & full & ~pop) overflowError <= 1'b1;
      slowDown <= near_full;
    end
  end

  assign seriesSum      = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign seriesSumValid = ~empty;
  assign seriesCount    = series_count;

`ifdef PERMUTATION_COLLECTOR_COUNT_CHECK_EN
  // count_inc is the final count including the closing element.
  always_ff @(posedge clk) begin
    if (rst) begin
      countError <= 1'b0;
    end else if (s1_close && (count_inc != 16'(SERIES_LENGTH))) begin
      countError <= 1'b1;
    end
  end
`else
  assign countError = 1'b0;
`endif

endmodule

// File: tb/tb_permutation_result_collector.sv
// Directed bench for permutation_result_collector, built with a 4-entry FIFO and a margin of 2.
module tb_permutation_result_collector;

  localparam int RW = 48;
  localparam int SW = 54;

`ifdef PERMUTATION_COLLECTOR_COUNT_CHECK_EN
  localparam logic EXP_CE = 1'b1;
`else
  localparam logic EXP_CE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [RW-1:0] resultIn = '0;
  logic          resultInValid = 1'b0;
  logic          botSeriesFinished = 1'b0;
  logic          slowDown;
  logic [SW-1:0] seriesSum;
  logic          seriesSumValid;
  logic          readSeriesSum = 1'b0;
  logic [15:0]   seriesCount;
  logic          overflowError;
  logic          countError;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  permutation_result_collector #(
    .RESULT_WIDTH(RW), .SUM_WIDTH(SW), .SERIES_LENGTH(42),
    .DEPTH_LOG2(2), .ALMOST_FULL_MARGIN(2)
  ) dut (
    .clk(clk), .rst(rst), .resultIn(resultIn), .resultInValid(resultInValid),
    .botSeriesFinished(botSeriesFinished), .slowDown(slowDown), .seriesSum(seriesSum),
    .seriesSumValid(seriesSumValid), .readSeriesSum(readSeriesSum),
    .seriesCount(seriesCount), .overflowError(overflowError), .countError(countError)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; resultInValid = 1'b0; botSeriesFinished = 1'b0; readSeriesSum = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic drive_elem(input logic [RW-1:0] v, input logic fin);
    resultIn = v; resultInValid = 1'b1; botSeriesFinished = fin;
    step();
  endtask

  task automatic idle(input logic fin);
    resultIn = '0; resultInValid = 1'b0; botSeriesFinished = fin;
    step();
    botSeriesFinished = 1'b0;
  endtask

  task automatic drive_series(input logic [RW-1:0] v, input int len);
    for (int i = 1; i <= len; i++) drive_elem(v, i == len);
    resultInValid = 1'b0; botSeriesFinished = 1'b0;
  endtask

  task automatic pop_once();
    readSeriesSum = 1'b1;
    step();
    readSeriesSum = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    checks++; if (seriesSumValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", seriesSumValid); end
    checks++; if (seriesSum !== '0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", seriesSum); end
    checks++; if (seriesCount !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", seriesCount); end
    checks++; if ({slowDown, overflowError, countError} !== 3'b000) begin errors++;
      $display("FAIL reset_flags: got %b expected 000", {slowDown, overflowError, countError}); end
  endtask

  task automatic test_single_series();
    apply_reset();
    for (int i = 1; i <= 10; i++) drive_elem(48'd1, 1'b0);
    checks++; if (seriesCount !== 16'd9) begin errors++; $display("FAIL single_midcount: got %0d expected 9", seriesCount); end
    for (int i = 11; i <= 42; i++) drive_elem(48'd1, i == 42);
    resultInValid = 1'b0; botSeriesFinished = 1'b0;
    step();
    checks++; if (seriesSumValid !== 1'b0) begin errors++; $display("FAIL single_early: got %0b expected 0 at T+2", seriesSumValid); end
    checks++; if (seriesCount !== 16'd0) begin errors++; $display("FAIL single_count_clear: got %0d expected 0", seriesCount); end
    step();
    checks++; if (seriesSumValid !== 1'b1) begin errors++; $display("FAIL single_latency: got %0b expected 1 at T+3", seriesSumValid); end
    checks++; if (seriesSum !== 54'd42) begin errors++; $display("FAIL single_sum: got %0d expected 42", seriesSum); end
    checks++; if ({countError, slowDown} !== 2'b00) begin errors++; $display("FAIL single_flags: got %b expected 00", {countError, slowDown}); end
    pop_once();
    checks++; if (seriesSumValid !== 1'b0) begin errors++; $display("FAIL single_pop_empty: got %0b expected 0", seriesSumValid); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 1; i <= 42; i++) begin
        if (i % 7 == 3) idle(i % 14 == 3);
        drive_elem(s == 0 ? 48'hFFFF_FFFF_FFFF : 48'd2, i == 42);
      end
    end
    resultInValid = 1'b0; botSeriesFinished = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (slowDown !== 1'b1) begin errors++; $display("FAIL b2b_slowdown: got %0b expected 1", slowDown); end
    checks++; if (seriesSum !== 54'h29_FFFF_FFFF_FFD6) begin errors++; $display("FAIL b2b_sum_a: got %0h expected 29ffffffffffd6", seriesSum); end
    pop_once();
    checks++; if (seriesSum !== 54'd84 || seriesSumValid !== 1'b1) begin errors++;
      $display("FAIL b2b_sum_b: got %0d valid %0b expected 84 valid 1", seriesSum, seriesSumValid); end
    pop_once();
    checks++; if (seriesSumValid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %0b expected 0", seriesSumValid); end
  endtask

  task automatic test_overflow();
    logic [SW-1:0] exp_sum;
    apply_reset();
    for (int i = 1; i <= 5; i++) drive_elem(48'd1, 1'b0);
    checks++; if (slowDown !== 1'b0) begin errors++; $display("FAIL ovf_slow_low: got %0b expected 0", slowDown); end
    for (int i = 6; i <= 42; i++) drive_elem(48'd1, i == 42);
    for (int i = 1; i <= 5; i++) drive_elem(48'd2, 1'b0);
    checks++; if (slowDown !== 1'b1) begin errors++; $display("FAIL ovf_slow_high: got %0b expected 1", slowDown); end
    for (int i = 6; i <= 42; i++) drive_elem(48'd2, i == 42);
    drive_series(48'd3, 42);
    drive_series(48'd4, 42);
    for (int i = 1; i <= 10; i++) drive_elem(48'd5, 1'b0);
    checks++; if (overflowError !== 1'b0) begin errors++; $display("FAIL ovf_not_early: got %0b expected 0", overflowError); end
    for (int i = 11; i <= 42; i++) drive_elem(48'd5, i == 42);
    resultInValid = 1'b0; botSeriesFinished = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++; if (overflowError !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b expected 1", overflowError); end
    for (int k = 1; k <= 4; k++) begin
      exp_sum = SW'(42 * k);
      checks++; if (seriesSumValid !== 1'b1 || seriesSum !== exp_sum) begin errors++;
        $display("FAIL ovf_entry%0d: got %0d valid %0b expected %0d", k, seriesSum, seriesSumValid, exp_sum); end
      pop_once();
    end
    checks++; if (seriesSumValid !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got valid %0b expected 0", seriesSumValid); end
  endtask

  task automatic test_pop_push_race();
    logic [SW-1:0] exp_sum;
    apply_reset();
    for (int k = 1; k <= 5; k++) drive_series(RW'(k), 42);
    step();
    // S2 holds the fifth total now; pop during the cycle it writes.
    pop_once();
    checks++; if (overflowError !== 1'b0) begin errors++; $display("FAIL race_overflow: got %0b expected 0", overflowError); end
    for (int k = 2; k <= 5; k++) begin
      exp_sum = SW'(42 * k);
      checks++; if (seriesSumValid !== 1'b1 || seriesSum !== exp_sum) begin errors++;
        $display("FAIL race_entry%0d: got %0d valid %0b expected %0d", k, seriesSum, seriesSumValid, exp_sum); end
      pop_once();
    end
    checks++; if (seriesSumValid !== 1'b0) begin errors++; $display("FAIL race_occupancy: got valid %0b expected 0", seriesSumValid); end
  endtask

  task automatic test_count_check();
    apply_reset();
    drive_series(48'd1, 41);
    checks++; if (countError !== 1'b0) begin errors++; $display("FAIL count_early: got %0b expected 0", countError); end
    step();
    checks++; if (countError !== EXP_CE) begin errors++; $display("FAIL count_flag: got %0b expected %0b", countError, EXP_CE); end
    step();
    checks++; if (seriesSum !== 54'd41 || seriesSumValid !== 1'b1) begin errors++;
      $display("FAIL count_stored: got %0d valid %0b expected 41", seriesSum, seriesSumValid); end
    for (int k = 0; k < 3; k++) step();
    checks++; if (countError !== EXP_CE) begin errors++; $display("FAIL count_sticky: got %0b expected %0b", countError, EXP_CE); end
  endtask

  task automatic test_reset_mid_series();
    apply_reset();
    drive_series(48'd7, 42);
    for (int i = 1; i <= 20; i++) drive_elem(48'd5, 1'b0);
    checks++; if (slowDown !== 1'b1) begin errors++; $display("FAIL rst_pre_slow: got %0b expected 1", slowDown); end
    rst = 1'b1; resultInValid = 1'b0;
    step();
    checks++; if (slowDown !== 1'b0 || seriesSumValid !== 1'b0 || seriesCount !== 16'd0) begin errors++;
      $display("FAIL rst_during: got slow %0b valid %0b count %0d expected 0 0 0", slowDown, seriesSumValid, seriesCount); end
    rst = 1'b0;
    drive_series(48'd3, 42);
    for (int k = 0; k < 4; k++) step();
    checks++; if (seriesSum !== 54'd126 || seriesSumValid !== 1'b1) begin errors++;
      $display("FAIL rst_sum: got %0d valid %0b expected 126", seriesSum, seriesSumValid); end
    checks++; if ({slowDown, overflowError, countError} !== 3'b000) begin errors++;
      $display("FAIL rst_flags: got %b expected 000", {slowDown, overflowError, countError}); end
    pop_once();
    checks++; if (seriesSumValid !== 1'b0) begin errors++; $display("FAIL rst_single_output: got valid %0b expected 0", seriesSumValid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_series();
    test_back_to_back();
    test_overflow();
    test_pop_push_race();
    test_count_check();
    test_reset_mid_series();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
